// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, per-bit oversampling with a 3-sample
// mid-bit majority vote, optional parity, one-cycle data/error strobes.
module uart_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 state_q, state_d;
   logic                   rx_meta, rx_s;
   logic [5:0]             edge_cnt;
   logic [CNT_W-1:0]       bit_cnt;
   logic [2:0]             samp;
   logic [DATA_WIDTH-1:0]  shift_reg;
   logic                   par_en_q, par_typ_q, par_err_q;
   logic [5:0]             prescale_q;

   logic [5:0] half;
   logic       samp_lo, samp_mid, samp_hi, decide, bit_end;
   logic       majority, exp_par;

   // Sample window is centred on the middle of the bit; the decision lands one
   // cycle after the last sample so the vote sees all three registered samples.
   assign half     = prescale_q >> 1;
   assign samp_lo  = (edge_cnt == half - 6'd1);
   assign samp_mid = (edge_cnt == half);
   assign samp_hi  = (edge_cnt == half + 6'd1);
   assign decide   = (edge_cnt == half + 6'd2);
   assign bit_end  = (edge_cnt == prescale_q - 6'd1);
   assign majority = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
   assign exp_par  = par_typ_q ^ (^shift_reg);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // STOP leaves at the decision point rather than the bit end so a start bit
   // immediately following the stop bit is not missed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!rx_s) state_d = START;
         START: begin
            if (decide && majority) state_d = IDLE;
            else if (bit_end)       state_d = DATA;
         end
         DATA:    if (bit_end && bit_cnt == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
         PARITY:  if (bit_end) state_d = STOP;
         STOP:    if (decide) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         samp       <= '0;
         shift_reg  <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         par_err_q  <= 1'b0;
         prescale_q <= '0;
         P_DATA     <= '0;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
      end else begin
         rx_meta    <= RX_IN;
         rx_s       <= rx_meta;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
         if (state_q == IDLE) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            par_err_q <= 1'b0;
            // Configuration is frozen here for the whole frame.
            if (!rx_s) begin
               edge_cnt   <= 6'd1;
               par_en_q   <= PAR_EN;
               par_typ_q  <= PAR_TYP;
               prescale_q <= Prescale;
            end
         end else begin
            edge_cnt <= bit_end ? '0 : edge_cnt + 6'd1;
            if (samp_lo)  samp[0] <= rx_s;
            if (samp_mid) samp[1] <= rx_s;
            if (samp_hi)  samp[2] <= rx_s;
            case (state_q)
               DATA: begin
                  if (decide)  shift_reg <= {majority, shift_reg[DATA_WIDTH-1:1]};
                  if (bit_end) bit_cnt   <= bit_cnt + CNT_W'(1);
               end
               PARITY: begin
                  if (decide && (majority != exp_par)) par_err_q <= 1'b1;
               end
               STOP: begin
                  // Data is only published for a frame with no error at all.
                  if (decide) begin
                     STP_ERR <= ~majority;
                     PAR_ERR <= par_err_q;
                     if (majority && !par_err_q) begin
                        P_DATA     <= shift_reg;
                        DATA_VALID <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of whole frames plus hand-written
// sequences for glitch rejection, back-to-back frames, reset and noise spikes.
module tb_uart_rx;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic [7:0] P_DATA;
   logic       DATA_VALID, PAR_ERR, STP_ERR;

   int tests = 0;
   int failed = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic       dv, pe, se;
      logic [7:0] pd;
   } ev_t;
   ev_t evq[$];

   typedef struct {
      logic [5:0] presc;
      logic       par_en, par_typ;
      logic [7:0] data;
      logic       par_bit, stop_bit;
      logic       exp_dv, exp_pe, exp_se;
      logic [7:0] exp_pd;
   } vec_t;
   vec_t vecs[4];

   uart_rx #(.DATA_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .Prescale(Prescale), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
      .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Every strobe cycle is logged, so a stretched or spurious pulse shows up as
   // an extra queue entry.
   always @(negedge CLK) begin
      if (DATA_VALID || PAR_ERR || STP_ERR)
         evq.push_back('{cyc, DATA_VALID, PAR_ERR, STP_ERR, P_DATA});
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   function automatic int latency(input int p, input logic pen);
      int fb;
      fb = 10 + (pen ? 1 : 0);
      return 2 + (fb - 1) * p + p / 2 + 3;
   endfunction

   // Drives one frame, each bit exactly p cycles; optionally inverts a single
   // cycle at the middle of bit index spike_bit.
   task automatic sendFrame(input int p, input logic [7:0] d, input logic pen,
                            input logic pbit, input logic sbit, input int spike_bit,
                            output int start_cyc);
      logic bits[12];
      int   n;
      n = 0;
      bits[n++] = 1'b0;
      for (int i = 0; i < 8; i++) bits[n++] = d[i];
      if (pen) bits[n++] = pbit;
      bits[n++] = sbit;
      start_cyc = cyc;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < p; k++) begin
            RX_IN = (i == spike_bit && k == p / 2) ? ~bits[i] : bits[i];
            @(posedge CLK);
            #1;
         end
      end
   endtask

   task automatic expectEvent(input string name, input int start_cyc, input int lat,
                              input logic dv, input logic pe, input logic se, input logic [7:0] pd);
      int   waited;
      ev_t  ev;
      waited = 0;
      while (evq.size() == 0 && waited < lat + 200) begin
         @(posedge CLK);
         #1;
         waited++;
      end
      if (evq.size() == 0) begin
         tests++;
         failed++;
         $display("[TB] FAIL %s timeout: got no strobe expected one", name);
      end else begin
         ev = evq.pop_front();
         checkOutput({name, " latency"}, ev.cyc - start_cyc, lat);
         checkOutput({name, " DATA_VALID"}, {31'd0, ev.dv}, {31'd0, dv});
         checkOutput({name, " PAR_ERR"}, {31'd0, ev.pe}, {31'd0, pe});
         checkOutput({name, " STP_ERR"}, {31'd0, ev.se}, {31'd0, se});
         checkOutput({name, " P_DATA"}, {24'd0, ev.pd}, {24'd0, pd});
      end
   endtask

   task automatic checkNoEvents(input string name);
      checkOutput({name, " extra strobes"}, evq.size(), 0);
      evq.delete();
   endtask

   task automatic applyStimulus(input int idx);
      int s, p;
      p        = int'(vecs[idx].presc);
      Prescale = vecs[idx].presc;
      PAR_EN   = vecs[idx].par_en;
      PAR_TYP  = vecs[idx].par_typ;
      idleCycles(2);
      sendFrame(p, vecs[idx].data, vecs[idx].par_en, vecs[idx].par_bit,
                vecs[idx].stop_bit, -1, s);
      RX_IN = 1'b1;
      idleCycles(p);
      expectEvent($sformatf("vec%0d", idx), s, latency(p, vecs[idx].par_en),
                  vecs[idx].exp_dv, vecs[idx].exp_pe, vecs[idx].exp_se, vecs[idx].exp_pd);
      idleCycles(2 * p);
      checkNoEvents($sformatf("vec%0d", idx));
      checkOutput($sformatf("vec%0d P_DATA held", idx), {24'd0, P_DATA}, {24'd0, vecs[idx].exp_pd});
   endtask

   initial begin
      int s1, s2;
      vecs[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
      vecs[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
      vecs[2] = '{6'd32, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81};
      vecs[3] = '{6'd32, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81};

      idleCycles(3);
      RST = 1'b1;
      idleCycles(3);
      checkOutput("reset P_DATA", {24'd0, P_DATA}, 32'd0);
      checkOutput("reset DATA_VALID", {31'd0, DATA_VALID}, 32'd0);
      checkOutput("reset PAR_ERR", {31'd0, PAR_ERR}, 32'd0);
      checkOutput("reset STP_ERR", {31'd0, STP_ERR}, 32'd0);

      for (int i = 0; i < 4; i++) applyStimulus(i);

      // Two-cycle low pulse must be voted away in START.
      Prescale = 6'd16;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      idleCycles(2);
      RX_IN = 1'b1;
      idleCycles(60);
      checkNoEvents("glitch");
      checkOutput("glitch P_DATA held", {24'd0, P_DATA}, 32'h81);
      sendFrame(16, 8'h0F, 1'b0, 1'b0, 1'b1, -1, s1);
      RX_IN = 1'b1;
      expectEvent("after glitch", s1, latency(16, 1'b0), 1'b1, 1'b0, 1'b0, 8'h0F);
      idleCycles(40);
      checkNoEvents("after glitch");

      Prescale = 6'd8;
      idleCycles(2);
      sendFrame(8, 8'h12, 1'b0, 1'b0, 1'b1, -1, s1);
      sendFrame(8, 8'h34, 1'b0, 1'b0, 1'b1, -1, s2);
      RX_IN = 1'b1;
      expectEvent("b2b first", s1, latency(8, 1'b0), 1'b1, 1'b0, 1'b0, 8'h12);
      expectEvent("b2b second", s2, latency(8, 1'b0), 1'b1, 1'b0, 1'b0, 8'h34);
      idleCycles(20);
      checkNoEvents("b2b");

      Prescale = 6'd16;
      RX_IN    = 1'b0;
      idleCycles(40);
      RST = 1'b0;
      #1;
      checkOutput("midreset P_DATA", {24'd0, P_DATA}, 32'd0);
      checkOutput("midreset DATA_VALID", {31'd0, DATA_VALID}, 32'd0);
      checkOutput("midreset PAR_ERR", {31'd0, PAR_ERR}, 32'd0);
      checkOutput("midreset STP_ERR", {31'd0, STP_ERR}, 32'd0);
      idleCycles(3);
      RX_IN = 1'b1;
      idleCycles(2);
      RST = 1'b1;
      idleCycles(200);
      checkNoEvents("midreset");

      sendFrame(16, 8'h00, 1'b0, 1'b0, 1'b1, 4, s1);
      RX_IN = 1'b1;
      expectEvent("spike", s1, latency(16, 1'b0), 1'b1, 1'b0, 1'b0, 8'h00);
      idleCycles(40);
      checkNoEvents("spike");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the receive-side counterpart of the UART transmitter, same frame format. The frame is start bit (0), DATA_WIDTH data bits LSB-first, an optional parity bit, then stop bit (1). The line is oversampled by a runtime Prescale. Each bit is decided by a 3-sample majority vote at mid-bit. The block delivers parallel data with a one-cycle valid strobe, plus parity and stop error flags.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
CLK  input  1  system clock, Prescale x baud rate.
RST  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, idle high; asynchronous to CLK.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Prescale  input  6  oversampling ratio; legal values are 8, 16 and 32 only.
P_DATA  output  DATA_WIDTH  received data; held until the next valid frame.
DATA_VALID  output  1  one-cycle pulse when P_DATA is updated with a good frame.
PAR_ERR  output  1  one-cycle pulse, parity mismatch on the completed frame.
STP_ERR  output  1  one-cycle pulse, stop bit sampled as 0.

Behaviour:
- Reset (RST=0, async): all outputs 0. P_DATA=0. FSM goes to IDLE. All counters and the synchronizer are cleared. The synchronizer resets to 1.
- RX_IN passes through a 2-flop synchronizer (rx_s). All logic uses rx_s. Fixed input latency: 2 cycles.
- Configuration capture: PAR_EN, PAR_TYP and Prescale are captured on the IDLE->START transition. They are held for the whole frame. Changes mid-frame have no effect.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit and wraps to 0 at the bit boundary.
  - bit_cnt counts bits within the frame.
- Sampling: samples are taken at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. The bit value is the majority of the three, registered at edge_cnt = Prescale/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rx_s=0, go to START with edge_cnt=1. The detecting cycle counts as edge 0.
  - START: evaluate the bit at the decision point.
    - Bit = 1 (glitch): return to IDLE. No outputs fire.
    - Bit = 0: continue to the end of the bit, then go to DATA.
  - DATA: shift the decided bit into a shift register LSB-first. After DATA_WIDTH bits go to PARITY if PAR_EN=1, otherwise go to STOP.
  - PARITY: compare the decided bit with the expected value.
    - Expected = XOR(data) when PAR_TYP=0.
    - Expected = ~XOR(data) when PAR_TYP=1.
    - On mismatch, latch a parity error. Go to STOP at the end of the bit.
  - STOP: at the decision point, complete the frame, then go to IDLE immediately without waiting for the end of the bit. This allows a back-to-back start bit to be detected.
- Frame completion, all on the cycle after the stop decision:
  - STP_ERR=1 if the stop bit = 0.
  - PAR_ERR=1 if a parity error was latched.
  - If there is no error: P_DATA <= shift register and DATA_VALID=1.
  - If there is any error: DATA_VALID stays 0 and P_DATA is unchanged.
  - All three strobes are exactly 1 cycle wide.
- Latency: DATA_VALID rises 2 (sync) + (frame_bits-1)*Prescale + Prescale/2+3 cycles after the RX_IN falling edge. frame_bits = DATA_WIDTH+2 (+1 with parity).
- Line held low (break): stop = 0 gives STP_ERR. The FSM then returns to IDLE and immediately starts a new frame while the line is still 0. This is accepted behaviour.
- Reset asserted mid-frame: the frame is discarded, no strobes fire, and the block is in IDLE with all outputs 0.
- Illegal Prescale values are unsupported; behaviour is undefined.

Test Plan:
1. Prescale=8, PAR_EN=0, frame 0xA5 -> P_DATA=0xA5. DATA_VALID high 1 cycle at the computed latency. PAR_ERR=STP_ERR=0.
2. Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C with parity bit 1 (wrong) -> PAR_ERR pulse. DATA_VALID=0. P_DATA keeps its previous value.
3. Prescale=32, PAR_EN=1, PAR_TYP=1, 0x81 with correct parity 1 -> P_DATA=0x81 and DATA_VALID pulse. Next, 0x55 with stop bit 0 -> STP_ERR pulse and no DATA_VALID.
4. Glitch: RX_IN low for 2 CLK cycles at Prescale=16 -> START rejects it and returns to IDLE. No strobes. A following valid 0x0F frame is received correctly.
5. Back-to-back frames 0x12, 0x34 with no idle gap, Prescale=8 -> two DATA_VALID pulses in order, with 0x12 then 0x34 on P_DATA.
6. Single-sample noise spike: RX_IN=1 for 1 cycle at the middle of data bit 3 (value 0) of 0x00 -> the majority vote yields 0x00 and DATA_VALID fires. Assert RST mid-frame -> all outputs 0 and no strobe.
